uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter peripheral on the 8-bit CPU bus, a sibling of the GPIO output port.
- Consumes bytes the CPU writes and serialises them as 8N1 frames on `tx`.
- Buffers writes in a small FIFO so the CPU stalls, by withholding ready, only when the FIFO is full.
- Decoded by the top level into a 2-byte window in the upper address space.

---
 rtl/uart_tx_mmio.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a 4-deep write FIFO (DATA at 0, STATUS at 1).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.

module uart_tx_mmio #(
  parameter int size_addr = 1,
  parameter int size      = 2,
  parameter int fifo_addr = 2,
  parameter int clk_div   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read,
  input  logic                 write,
  output logic                 ready_r,
  output logic                 ready_w,
  input  logic [size_addr-1:0] address,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 tx
);

  localparam int                   DEPTH       = 2 ** fifo_addr;
  localparam logic [size_addr-1:0] STATUS_ADDR = size_addr'(size - 1);
  localparam logic [7:0]           BAUD_LOAD   = 8'(clk_div - 1);
  localparam logic [fifo_addr:0]   PTR_ONE     = (fifo_addr + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [7:0]           baud_q, baud_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 ready_r_q, ready_r_d;
  logic                 ready_w_q, ready_w_d;
  logic                 done_q, done_d;
  logic [7:0]           data_out_q, data_out_d;
  logic [fifo_addr:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]           fifo_q [DEPTH];
  logic                 push, pop, full, empty, is_status;
  logic [7:0]           head, status;

`ifdef UART_TX_PARITY_EN
  localparam logic HAS_PARITY = 1'b1;
  logic parity_q, parity_d;
`else
  localparam logic HAS_PARITY = 1'b0;
`endif

  // The extra wrap bit distinguishes full from empty when the low bits match.
  assign full      = (wr_ptr_q[fifo_addr] != rd_ptr_q[fifo_addr]) &&
                     (wr_ptr_q[fifo_addr-1:0] == rd_ptr_q[fifo_addr-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign is_status = (address == STATUS_ADDR);
  assign head      = fifo_q[rd_ptr_q[fifo_addr-1:0]];
  assign status    = {4'b0000, HAS_PARITY, state_q != S_IDLE, empty, full};

  // Bus side: done_q allows a single push per write-high period.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ready_r_d  = read;
    data_out_d = data_out_q;
    ready_w_d  = 1'b0;
    done_d     = 1'b0;
    push       = 1'b0;
    if (read) data_out_d = is_status ? status : 8'h00;
    if (write) begin
      done_d    = done_q;
      ready_w_d = done_q;
      if (!done_q && (is_status || !full)) begin
        push      = !is_status;
        done_d    = 1'b1;
        ready_w_d = 1'b1;
      end
    end
  end

  // Transmit FSM; tx is registered and follows the next state.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = head;
          baud_d   = BAUD_LOAD;
          state_d  = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      default: begin
        if (baud_q != 8'd0) begin
          baud_d = baud_q - 8'd1;
        end else begin
          baud_d = BAUD_LOAD;
          case (state_q)
            S_START: begin
              state_d   = S_DATA;
              bit_cnt_d = 3'd0;
            end
            S_DATA: begin
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_d = S_PARITY;
`else
                state_d = S_STOP;
`endif
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shift_d   = {1'b0, shift_q[7:1]};
              end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: state_d = S_STOP;
`endif
            default:  state_d = S_IDLE;
          endcase
        end
      end
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= 8'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      ready_r_q  <= 1'b0;
      ready_w_q  <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ready_r_q  <= ready_r_d;
      ready_w_q  <= ready_w_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[fifo_addr-1:0]] <= data_in;
  end

  assign tx       = tx_q;
  assign ready_r  = ready_r_q;
  assign ready_w  = ready_w_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected frames and read data,
// independent monitors on tx and ready_r pop and compare.

module tb_uart_tx_mmio;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int         NB       = 11;
  localparam logic [7:0] PAR_FLAG = 8'h08;
`else
  localparam int         NB       = 10;
  localparam logic [7:0] PAR_FLAG = 8'h00;
`endif
  localparam int         FRAME_CYC = NB * CLK_DIV;
  localparam logic [7:0] ST_EMPTY  = 8'h02 | PAR_FLAG;
  localparam logic [7:0] ST_BUSY_E = 8'h06 | PAR_FLAG;
  localparam logic [7:0] ST_FULL   = 8'h05 | PAR_FLAG;

  logic       clk = 1'b0;
  logic       reset, read, write;
  logic       address;
  logic [7:0] data_in;
  logic       ready_r, ready_w, tx;
  logic [7:0] data_out;

  uart_tx_mmio #(.size_addr(1), .size(2), .fifo_addr(2), .clk_div(CLK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .ready_r  (ready_r),
    .ready_w  (ready_w),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_frame_q [$];
  logic [7:0] exp_rd_q [$];
  int         frame_start [$];
  int         aborted_cnt = 0;
  bit         abort_pending = 1'b0;
  int         last_ack_cyc;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Serial monitor: checks every cycle of each frame against the expected byte.
  logic [7:0] mon_b;
  logic       mon_bits [NB];
  int         mon_bad;
  bit         mon_ab;
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        frame_start.push_back(cyc);
        check(exp_frame_q.size() > 0, "frame_expected", exp_frame_q.size(), 1);
        mon_b = (exp_frame_q.size() > 0) ? exp_frame_q.pop_front() : 8'h00;
        mon_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) mon_bits[i+1] = mon_b[i];
`ifdef UART_TX_PARITY_EN
        mon_bits[9] = ^mon_b;
`endif
        mon_bits[NB-1] = 1'b1;
        mon_bad = 0;
        mon_ab  = 1'b0;
        for (int k = 0; k < FRAME_CYC && !mon_ab; k++) begin
          if (k > 0) @(negedge clk);
          if (abort_pending) begin
            mon_ab        = 1'b1;
            abort_pending = 1'b0;
            aborted_cnt++;
          end else if (tx !== mon_bits[k / CLK_DIV]) begin
            mon_bad++;
          end
        end
        if (!mon_ab) check(mon_bad == 0, $sformatf("frame_%02h_bad_cycles", mon_b), mon_bad, 0);
      end
    end
  end

  // Read monitor: compares data_out on each rising ready_r.
  logic rr_prev = 1'b0;
  logic [7:0] rd_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (ready_r === 1'b1 && !rr_prev) begin
        check(exp_rd_q.size() > 0, "read_expected", exp_rd_q.size(), 1);
        rd_exp = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 8'h00;
        check(data_out === rd_exp, "read_data", data_out, rd_exp);
      end
      rr_prev = (ready_r === 1'b1);
    end
  end

  task automatic bus_read(input logic a, input logic [7:0] exp);
    int n;
    @(negedge clk);
    address = a;
    read    = 1'b1;
    exp_rd_q.push_back(exp);
    n = 0;
    while (ready_r !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(n == 1, "read_ack_latency", n, 1);
    read = 1'b0;
    @(negedge clk);
    check(ready_r === 1'b0, "ready_r_drop", ready_r, 0);
  endtask

  // exp_lat < 0 skips the latency check (stalled writes are checked by the caller).
  task automatic bus_write(input logic a, input logic [7:0] d, input int hold, input int exp_lat);
    int n;
    @(negedge clk);
    address = a;
    data_in = d;
    write   = 1'b1;
    n = 0;
    while (ready_w !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    last_ack_cyc = cyc;
    check(ready_w === 1'b1, "write_ack", ready_w, 1);
    if (exp_lat >= 0) check(n == exp_lat, "write_ack_latency", n, exp_lat);
    repeat (hold) @(negedge clk);
    if (hold > 0) check(ready_w === 1'b1, "ready_w_held", ready_w, 1);
    write = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frame_start.size() < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(frame_start.size() >= target, "frame_wait", frame_start.size(), target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int base, exp_ack, s, n;
  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    check(tx === 1'b1, "reset_tx", tx, 1);
    check(ready_r === 1'b0, "reset_ready_r", ready_r, 0);
    check(ready_w === 1'b0, "reset_ready_w", ready_w, 0);
    check(data_out === 8'h00, "reset_data_out", data_out, 0);
    reset = 1'b0;
    bus_read(1'b1, ST_EMPTY);

    // Single byte; the FIFO is already drained into the shifter, so empty reads 1 while busy.
    exp_frame_q.push_back(8'hA5);
    bus_write(1'b0, 8'hA5, 0, 1);
    bus_read(1'b1, ST_BUSY_E);
    repeat (FRAME_CYC + 10) @(negedge clk);
    bus_read(1'b1, ST_EMPTY);
    check(frame_start.size() == 1, "frames_after_a5", frame_start.size(), 1);

    // 0x01 leaves at once, 0x02..0x05 fill the FIFO, 0x06 stalls until 0x02 is popped.
    base = frame_start.size();
    for (int i = 1; i <= 5; i++) begin
      exp_frame_q.push_back(8'(i));
      bus_write(1'b0, 8'(i), 0, 1);
    end
    bus_read(1'b1, ST_FULL);
    exp_frame_q.push_back(8'h06);
    bus_write(1'b0, 8'h06, 0, -1);
    exp_ack = (frame_start.size() > base + 1) ? frame_start[base+1] + 1 : -1;
    check(last_ack_cyc == exp_ack, "stall_ack_cycle", last_ack_cyc, exp_ack);
    wait_frames(base + 6);
    repeat (FRAME_CYC + 5) @(negedge clk);
    check(frame_start.size() == base + 6, "burst_frame_count", frame_start.size(), base + 6);
    if (frame_start.size() >= base + 6) begin
      for (int i = 0; i < 5; i++)
        check(frame_start[base+i+1] - frame_start[base+i] == FRAME_CYC + 1, "frame_gap",
              frame_start[base+i+1] - frame_start[base+i], FRAME_CYC + 1);
    end
    bus_read(1'b1, ST_EMPTY);

    // One long write high period yields one push only.
    base = frame_start.size();
    exp_frame_q.push_back(8'h3C);
    bus_write(1'b0, 8'h3C, 20, 1);
    repeat (2 * FRAME_CYC) @(negedge clk);
    check(frame_start.size() == base + 1, "held_write_frames", frame_start.size(), base + 1);
    bus_read(1'b1, ST_EMPTY);

    // Reset during data bit 3 of 0x55 with two bytes still queued.
    base = frame_start.size();
    exp_frame_q.push_back(8'h55);
    bus_write(1'b0, 8'h55, 0, 1);
    bus_write(1'b0, 8'h96, 0, 1);
    bus_write(1'b0, 8'h0F, 0, 1);
    wait_frames(base + 1);
    s = (frame_start.size() > base) ? frame_start[base] : cyc;
    n = 0;
    while (cyc < s + 4 * CLK_DIV + 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    abort_pending = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check(tx === 1'b1, "tx_after_reset", tx, 1);
    check(ready_w === 1'b0, "ready_w_after_reset", ready_w, 0);
    bus_read(1'b1, ST_EMPTY);
    repeat (3 * FRAME_CYC) @(negedge clk);
    check(aborted_cnt == 1, "aborted_frames", aborted_cnt, 1);
    check(frame_start.size() == base + 1, "frames_after_reset", frame_start.size(), base + 1);

    // DATA read is side-effect free; STATUS write is acknowledged and ignored.
    base = frame_start.size();
    bus_read(1'b0, 8'h00);
    bus_write(1'b1, 8'hFF, 0, 1);
    repeat (FRAME_CYC + 10) @(negedge clk);
    check(frame_start.size() == base, "status_write_no_frame", frame_start.size(), base);
    bus_read(1'b1, ST_EMPTY);

    check(exp_frame_q.size() == 0, "frames_outstanding", exp_frame_q.size(), 0);
    check(exp_rd_q.size() == 0, "reads_outstanding", exp_rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
